pipeline_fetch_driver: RTL and testbench
========================================

// Module: pipeline_fetch_driver
// PURPOSE
// Synthesisable fetch-side master for the instruction pipeline. Issues sequential PCs
// on the pipeline input handshake (DIR/ack, four-phase) and drains pipeline results
// on the output handshake (DOR/ack pulse) into a one-entry result register.
// Adds configurable widths, PC step, redirect (branch), an outstanding-token limit
// and downstream back-pressure. Sits between the fetch/branch logic and `pipeline`.
// PARAMETERS
// ADDR_WIDTH      32  width of PC / pipeline data_in
// DATA_WIDTH      32  width of pipeline data_out / result_data
// PC_STEP         4   PC increment per accepted issue (modulo 2^ADDR_WIDTH)
// RESET_PC        0   PC value after reset
// MAX_OUTSTANDING 4   max issued-but-not-drained tokens, >=1
// CNT_WIDTH       3   width of outstanding counter, must hold MAX_OUTSTANDING
// PORTS
// clk               in   1           clock, all logic on posedge
// reset             in   1           synchronous, active-high
// enable            in   1           permits starting a new issue
// redirect_valid    in   1           load redirect_pc into PC this edge
// redirect_pc       in   ADDR_WIDTH  redirect target
// pipeline_DIR      out  1           data-in-ready to pipeline
// pipeline_data_in  out  ADDR_WIDTH  PC being issued, stable while DIR=1
// ack_from_pipeline in   1           pipeline accepted data_in
// pipeline_DOR      in   1           pipeline data-out-ready
// pipeline_data_out in   DATA_WIDTH  pipeline result
// ack_to_pipeline   out  1           one-cycle pulse: result consumed
// result_valid      out  1           result_data holds an undelivered result
// result_data       out  DATA_WIDTH  captured result
// result_ready      in   1           downstream takes result this cycle
// outstanding       out  CNT_WIDTH   issued minus drained tokens
// pc                out  ADDR_WIDTH  next PC to issue
// protocol_error    out  1           sticky: DOR accepted with outstanding==0
// BEHAVIOUR
// Reset: DIR, ack_to_pipeline, result_valid, protocol_error, outstanding = 0;
//   data_in, result_data = 0; pc = RESET_PC; issue FSM IDLE, drain FSM WAIT.
//   Reset mid-handshake aborts it: DIR low after the reset edge, no replay.
// Issue FSM (IDLE, REQ, ACKED):
// - IDLE: if enable && outstanding<MAX_OUTSTANDING && !redirect_valid: data_in<=pc,
//   DIR<=1 -> REQ. Otherwise stay, DIR=0.
// - REQ: DIR and data_in held (enable low does not withdraw). On ack_from_pipeline:
//   DIR<=0, pc<=pc+PC_STEP (wraps), outstanding+1 -> ACKED.
// - ACKED: DIR=0; stay while ack_from_pipeline=1; ack low -> IDLE.
// - Latency: DIR rises 1 edge after qualifying IDLE; min issue period 3 cycles.
// Redirect: pc<=redirect_pc at any edge with redirect_valid, in any state; overrides
//   the +PC_STEP when coincident with ack. An in-flight REQ completes with old data_in.
// Drain FSM (WAIT, ACK):
// - WAIT: if pipeline_DOR && (!result_valid || result_ready): result_data<=data_out,
//   result_valid<=1, ack_to_pipeline<=1, outstanding-1 -> ACK. Else ack=0, no capture.
// - ACK: ack_to_pipeline<=0 -> WAIT; DOR ignored this cycle (pulse is exactly 1 cycle).
// Result reg: result_valid clears on result_ready&&result_valid unless reloaded same edge.
// Counter: simultaneous issue-ack and drain leave outstanding unchanged. Drain with
//   outstanding==0: counter stays 0, protocol_error<=1 (cleared only by reset).
// TESTING
// 1. enable=1, model acks 1 cycle after DIR, drops ack next: data_in 0,4,8,12; pc=16.
// 2. MAX_OUTSTANDING=4, DOR never: 4 issues then DIR stays 0, outstanding=4; one DOR ->
//    1-cycle ack pulse, outstanding=3, fifth issue (data_in=16) starts.
// 3. result_ready=0, DOR with 0xAA then held high: 0xAA captured, acked once; no further
//    ack until result_ready=1; then next value captured, ack pulse.
// 4. redirect_valid with redirect_pc=0x100 during REQ for PC 8: data_in 8 completes,
//    next data_in=0x100, then 0x104.
// 5. ADDR_WIDTH=8, RESET_PC=0xFC: issued 0xFC then 0x00 (wrap).
// 6. DOR with outstanding=0 -> protocol_error=1 sticky, outstanding=0; reset in REQ ->
//    DIR=0 after reset edge, pc=RESET_PC.

Source files
------------

// File: rtl/pipeline_fetch_driver.sv
// rtl/pipeline_fetch_driver.sv - fetch-side master: issues PCs into the pipeline and drains its results
// Issue side is a four-phase DIR/ack handshake; drain side acks each DOR with a one-cycle pulse.
module pipeline_fetch_driver #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int PC_STEP         = 4,
  parameter int RESET_PC        = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  pipeline_DIR,
  output logic [ADDR_WIDTH-1:0] pipeline_data_in,
  input  logic                  ack_from_pipeline,
  input  logic                  pipeline_DOR,
  input  logic [DATA_WIDTH-1:0] pipeline_data_out,
  output logic                  ack_to_pipeline,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_data,
  input  logic                  result_ready,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  protocol_error
);

  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'd0,
    ISSUE_REQ   = 2'd1,
    ISSUE_ACKED = 2'd2
  } issue_state_t;

  typedef enum logic {
    DRAIN_WAIT = 1'b0,
    DRAIN_ACK  = 1'b1
  } drain_state_t;

  localparam logic [CNT_WIDTH-1:0]  MAX_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT  = ADDR_WIDTH'(RESET_PC);

  issue_state_t issue_state, issue_next;
  drain_state_t drain_state, drain_next;

  logic                  dir_next;
  logic [ADDR_WIDTH-1:0] data_in_next;
  logic                  issue_done;
  logic                  ack_next;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  result_valid_next;
  logic [DATA_WIDTH-1:0] result_data_next;
  logic [CNT_WIDTH-1:0]  outstanding_next;
  logic                  protocol_error_next;

  // Issue FSM: DIR and data_in are registered, so DIR stays stable through REQ.
  always_comb begin
    issue_next   = issue_state;
    dir_next     = pipeline_DIR;
    data_in_next = pipeline_data_in;
    issue_done   = 1'b0;
    case (issue_state)
      ISSUE_IDLE: begin
        if (enable && (outstanding < MAX_CNT) && !redirect_valid) begin
          dir_next     = 1'b1;
          data_in_next = pc;
          issue_next   = ISSUE_REQ;
        end else begin
          dir_next = 1'b0;
        end
      end
      ISSUE_REQ: begin
        if (ack_from_pipeline) begin
          dir_next   = 1'b0;
          issue_done = 1'b1;
          issue_next = ISSUE_ACKED;
        end
      end
      ISSUE_ACKED: begin
        dir_next = 1'b0;
        if (!ack_from_pipeline) begin
          issue_next = ISSUE_IDLE;
        end
      end
      default: begin
        dir_next   = 1'b0;
        issue_next = ISSUE_IDLE;
      end
    endcase
  end

  // Drain FSM: the ACK state forces a gap so the ack pulse is exactly one cycle.
  always_comb begin
    drain_next = drain_state;
    ack_next   = 1'b0;
    capture    = 1'b0;
    if (drain_state == DRAIN_WAIT) begin
      if (pipeline_DOR && (!result_valid || result_ready)) begin
        capture    = 1'b1;
        ack_next   = 1'b1;
        drain_next = DRAIN_ACK;
      end
    end else begin
      drain_next = DRAIN_WAIT;
    end
  end

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (issue_done) begin
      pc_next = pc + STEP;
    end

    result_data_next  = result_data;
    result_valid_next = result_valid;
    if (capture) begin
      result_data_next  = pipeline_data_out;
      result_valid_next = 1'b1;
    end else if (result_valid && result_ready) begin
      result_valid_next = 1'b0;
    end

    // A drain with nothing outstanding is flagged but never underflows the counter.
    outstanding_next    = outstanding;
    protocol_error_next = protocol_error;
    if (capture && (outstanding == '0)) begin
      protocol_error_next = 1'b1;
    end
    if (issue_done && !capture) begin
      outstanding_next = outstanding + 1'b1;
    end else if (!issue_done && capture && (outstanding != '0)) begin
      outstanding_next = outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_state      <= ISSUE_IDLE;
      drain_state      <= DRAIN_WAIT;
      pipeline_DIR     <= 1'b0;
      pipeline_data_in <= '0;
      ack_to_pipeline  <= 1'b0;
      result_valid     <= 1'b0;
      result_data      <= '0;
      outstanding      <= '0;
      pc               <= PC_INIT;
      protocol_error   <= 1'b0;
    end else begin
      issue_state      <= issue_next;
      drain_state      <= drain_next;
      pipeline_DIR     <= dir_next;
      pipeline_data_in <= data_in_next;
      ack_to_pipeline  <= ack_next;
      result_valid     <= result_valid_next;
      result_data      <= result_data_next;
      outstanding      <= outstanding_next;
      pc               <= pc_next;
      protocol_error   <= protocol_error_next;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_driver.sv
// tb/tb_pipeline_fetch_driver.sv - directed bench for pipeline_fetch_driver
module tb_pipeline_fetch_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        pipeline_DIR;
  logic [31:0] pipeline_data_in;
  logic        ack_from_pipeline;
  logic        pipeline_DOR;
  logic [31:0] pipeline_data_out;
  logic        ack_to_pipeline;
  logic        result_valid;
  logic [31:0] result_data;
  logic        result_ready;
  logic [2:0]  outstanding;
  logic [31:0] pc;
  logic        protocol_error;

  logic        enable8;
  logic        ack8;
  logic        dir8;
  logic [7:0]  data_in8;
  logic        ack_to8;
  logic        rv8;
  logic [31:0] rd8;
  logic [2:0]  out8;
  logic [7:0]  pc8;
  logic        err8;

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_fetch_driver dut (
    .clk(clk), .reset(reset), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pipeline_DIR(pipeline_DIR), .pipeline_data_in(pipeline_data_in),
    .ack_from_pipeline(ack_from_pipeline), .pipeline_DOR(pipeline_DOR),
    .pipeline_data_out(pipeline_data_out), .ack_to_pipeline(ack_to_pipeline),
    .result_valid(result_valid), .result_data(result_data),
    .result_ready(result_ready), .outstanding(outstanding), .pc(pc),
    .protocol_error(protocol_error)
  );

  pipeline_fetch_driver #(.ADDR_WIDTH(8), .RESET_PC(8'hFC)) dut8 (
    .clk(clk), .reset(reset), .enable(enable8),
    .redirect_valid(1'b0), .redirect_pc(8'h00),
    .pipeline_DIR(dir8), .pipeline_data_in(data_in8),
    .ack_from_pipeline(ack8), .pipeline_DOR(1'b0),
    .pipeline_data_out(32'h0), .ack_to_pipeline(ack_to8),
    .result_valid(rv8), .result_data(rd8),
    .result_ready(1'b0), .outstanding(out8), .pc(pc8),
    .protocol_error(err8)
  );

  task automatic do_reset;
    reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ack_from_pipeline = 1'b0; pipeline_DOR = 1'b0; pipeline_data_out = '0;
    result_ready = 1'b0; enable8 = 1'b0; ack8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Pipeline-side handshake: wait for DIR, ack for one cycle, then drop ack.
  task automatic issue_one(output logic [31:0] d, output bit ok);
    ok = 1'b0; d = '0;
    for (int i = 0; i < 20; i++) begin
      if (pipeline_DIR) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      d = pipeline_data_in;
      ack_from_pipeline = 1'b1;
      @(negedge clk);
      ack_from_pipeline = 1'b0;
    end
  endtask

  task automatic test_reset;
    do_reset();
    asserts++; if (pipeline_DIR !== 1'b0) begin failures++; $display("FAIL reset_dir got %0b want 0", pipeline_DIR); end
    asserts++; if (pipeline_data_in !== 32'h0) begin failures++; $display("FAIL reset_data_in got %h want 0", pipeline_data_in); end
    asserts++; if (ack_to_pipeline !== 1'b0) begin failures++; $display("FAIL reset_ack got %0b want 0", ack_to_pipeline); end
    asserts++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got %0b want 0", result_valid); end
    asserts++; if (outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    asserts++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got %h want 0", pc); end
    asserts++; if (protocol_error !== 1'b0) begin failures++; $display("FAIL reset_err got %0b want 0", protocol_error); end
    asserts++; if (pc8 !== 8'hFC) begin failures++; $display("FAIL reset_pc8 got %h want fc", pc8); end
  endtask

  task automatic test_issue_seq;
    logic [31:0] d;
    bit ok;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue_one(d, ok);
      asserts++; if (!ok || d !== 32'(4 * k)) begin failures++; $display("FAIL issue_seq[%0d] got %h ok=%0b want %h", k, d, ok, 4 * k); end
    end
    asserts++; if (pc !== 32'd16) begin failures++; $display("FAIL issue_seq_pc got %h want 10", pc); end
    asserts++; if (outstanding !== 3'd4) begin failures++; $display("FAIL issue_seq_outstanding got %0d want 4", outstanding); end
  endtask

  task automatic test_outstanding_limit;
    logic [31:0] d;
    bit ok;
    bit saw_dir = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pipeline_DIR) saw_dir = 1'b1;
    end
    asserts++; if (saw_dir !== 1'b0) begin failures++; $display("FAIL limit_dir_blocked got 1 want 0"); end
    result_ready = 1'b1; pipeline_DOR = 1'b1; pipeline_data_out = 32'h55;
    @(negedge clk);
    pipeline_DOR = 1'b0;
    asserts++; if (ack_to_pipeline !== 1'b1) begin failures++; $display("FAIL limit_ack_pulse got %0b want 1", ack_to_pipeline); end
    asserts++; if (outstanding !== 3'd3) begin failures++; $display("FAIL limit_outstanding got %0d want 3", outstanding); end
    asserts++; if (result_data !== 32'h55) begin failures++; $display("FAIL limit_result got %h want 55", result_data); end
    @(negedge clk);
    asserts++; if (ack_to_pipeline !== 1'b0) begin failures++; $display("FAIL limit_ack_drop got %0b want 0", ack_to_pipeline); end
    asserts++; if (pipeline_DIR !== 1'b1 || pipeline_data_in !== 32'd16) begin failures++; $display("FAIL limit_fifth_issue got dir=%0b data=%h want 1/10", pipeline_DIR, pipeline_data_in); end
    issue_one(d, ok);
    enable = 1'b0;
    asserts++; if (outstanding !== 3'd4) begin failures++; $display("FAIL limit_refill got %0d want 4", outstanding); end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    bit ok;
    int acks = 0;
    do_reset();
    enable = 1'b1;
    issue_one(d, ok);
    issue_one(d, ok);
    enable = 1'b0;
    pipeline_DOR = 1'b1; pipeline_data_out = 32'hAA;
    @(negedge clk);
    asserts++; if (ack_to_pipeline !== 1'b1 || result_data !== 32'hAA || result_valid !== 1'b1) begin failures++; $display("FAIL bp_first got ack=%0b data=%h rv=%0b want 1/aa/1", ack_to_pipeline, result_data, result_valid); end
    pipeline_data_out = 32'hBB;
    repeat (5) begin
      @(negedge clk);
      if (ack_to_pipeline) acks++;
    end
    asserts++; if (acks !== 0 || result_data !== 32'hAA) begin failures++; $display("FAIL bp_stall got acks=%0d data=%h want 0/aa", acks, result_data); end
    result_ready = 1'b1;
    @(negedge clk);
    asserts++; if (ack_to_pipeline !== 1'b1 || result_data !== 32'hBB || outstanding !== 3'd0) begin failures++; $display("FAIL bp_second got ack=%0b data=%h out=%0d want 1/bb/0", ack_to_pipeline, result_data, outstanding); end
    pipeline_DOR = 1'b0;
    @(negedge clk);
    asserts++; if (ack_to_pipeline !== 1'b0 || result_valid !== 1'b0) begin failures++; $display("FAIL bp_clear got ack=%0b rv=%0b want 0/0", ack_to_pipeline, result_valid); end
    asserts++; if (protocol_error !== 1'b0) begin failures++; $display("FAIL bp_err got %0b want 0", protocol_error); end
    result_ready = 1'b0;
  endtask

  task automatic test_redirect;
    logic [31:0] d;
    bit ok = 1'b0;
    do_reset();
    enable = 1'b1;
    issue_one(d, ok);
    issue_one(d, ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pipeline_DIR) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    asserts++; if (!ok || pipeline_data_in !== 32'd8) begin failures++; $display("FAIL redir_inflight got %h ok=%0b want 8", pipeline_data_in, ok); end
    ack_from_pipeline = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    ack_from_pipeline = 1'b0; redirect_valid = 1'b0;
    asserts++; if (pc !== 32'h100 || outstanding !== 3'd3) begin failures++; $display("FAIL redir_pc got pc=%h out=%0d want 100/3", pc, outstanding); end
    issue_one(d, ok);
    asserts++; if (!ok || d !== 32'h100) begin failures++; $display("FAIL redir_first got %h ok=%0b want 100", d, ok); end
    result_ready = 1'b1; pipeline_DOR = 1'b1;
    @(negedge clk);
    pipeline_DOR = 1'b0;
    issue_one(d, ok);
    enable = 1'b0;
    asserts++; if (!ok || d !== 32'h104) begin failures++; $display("FAIL redir_second got %h ok=%0b want 104", d, ok); end
    asserts++; if (pc !== 32'h108) begin failures++; $display("FAIL redir_pc_after got %h want 108", pc); end
  endtask

  task automatic test_wrap;
    logic [7:0] seen [2];
    bit ok;
    do_reset();
    enable8 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (dir8) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      seen[k] = ok ? data_in8 : 8'hxx;
      ack8 = 1'b1;
      @(negedge clk);
      ack8 = 1'b0;
    end
    enable8 = 1'b0;
    asserts++; if (seen[0] !== 8'hFC) begin failures++; $display("FAIL wrap_first got %h want fc", seen[0]); end
    asserts++; if (seen[1] !== 8'h00) begin failures++; $display("FAIL wrap_second got %h want 00", seen[1]); end
    asserts++; if (pc8 !== 8'h04) begin failures++; $display("FAIL wrap_pc got %h want 04", pc8); end
  endtask

  task automatic test_protocol_error;
    bit ok = 1'b0;
    do_reset();
    result_ready = 1'b1; pipeline_DOR = 1'b1; pipeline_data_out = 32'h77;
    @(negedge clk);
    pipeline_DOR = 1'b0;
    asserts++; if (protocol_error !== 1'b1 || outstanding !== 3'd0) begin failures++; $display("FAIL perr_set got err=%0b out=%0d want 1/0", protocol_error, outstanding); end
    repeat (3) @(negedge clk);
    asserts++; if (protocol_error !== 1'b1) begin failures++; $display("FAIL perr_sticky got %0b want 1", protocol_error); end
    result_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pipeline_DIR) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    asserts++; if (!ok) begin failures++; $display("FAIL perr_req got dir=0 want 1"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    asserts++; if (pipeline_DIR !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL reset_in_req got dir=%0b pc=%h want 0/0", pipeline_DIR, pc); end
    asserts++; if (protocol_error !== 1'b0) begin failures++; $display("FAIL perr_clear got %0b want 0", protocol_error); end
  endtask

  initial begin
    test_reset();
    test_issue_seq();
    test_outstanding_limit();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_protocol_error();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
